fpu_issue_scheduler: RTL
========================

Name: fpu_issue_scheduler

Overview:
- Shares the SIMD ALU+FPU datapath among NUM_WARPS warp requesters. Grants at most one warp instruction per cycle.
- Per-warp scoreboard blocks RAW/WAW hazards against in-flight fixed-latency FP results.
- Writeback-slot reservation ring prevents single-cycle ALU results from colliding with FP results on the one RF write port.
- Sits between the warp scheduler FSM and the datapath issue/writeback interface.

Parameters:
NUM_WARPS, 8, number of requesting warps (power of two, >=2)
FP_LATENCY, 4, FPU issue-to-writeback cycles (>=2)
REG_BITS, 5, register index width (2**REG_BITS regs per warp)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_WARPS  warp w has an instruction ready
req_is_fp  in  NUM_WARPS  instruction of warp w targets FPU (else integer ALU)
req_rd  in  NUM_WARPS*REG_BITS  packed destination index, warp w at [w*REG_BITS +: REG_BITS]
req_rs1  in  NUM_WARPS*REG_BITS  packed source 1 index
req_rs2  in  NUM_WARPS*REG_BITS  packed source 2 index
issue_stall  in  1  datapath cannot accept issue this cycle
grant  out  NUM_WARPS  one-hot issue grant (combinational, this cycle)
grant_valid  out  1  OR of grant
grant_warp  out  log2(NUM_WARPS)  index of granted warp (0 when none)
grant_is_fp  out  1  granted op is FP
wb_valid  out  1  RF write-port commit this cycle
wb_warp  out  log2(NUM_WARPS)  warp of committing result
wb_rd  out  REG_BITS  destination of committing result
wb_is_fp  out  1  committing result came from FPU
fp_inflight  out  log2(FP_LATENCY)+1  FP ops issued but not yet written back

Behaviour:
- Reset (async, rst_n=0): all slots invalid, scoreboard all zero, RR pointer=0, fp_inflight=0. wb_valid/wb_warp/wb_rd/wb_is_fp=0. grant outputs go 0 because no slot and no pointer state permits otherwise only when req=0. Reset mid-operation discards all in-flight reservations; no wb is produced for them.
- Slot ring slot[0..FP_LATENCY-1], each {valid, warp, rd, is_fp}. slot[0] drives wb_* directly (wb_valid=slot[0].valid; other fields 0 when invalid).
- Each edge: slot[k]<=slot[k+1] for k<FP_LATENCY-1, and slot[FP_LATENCY-1]<=invalid. Then the issue write below is applied.
- Eligibility of warp w, evaluated combinationally:
  - req[w]=1, and
  - pending[w][rs1], pending[w][rs2], pending[w][rd] all 0, and
  - if ALU op, slot[1].valid=0 (port collision check). FP ops never collide because only one issue occurs per cycle.
- Arbitration:
  - Round-robin over eligible warps, starting at pointer p. p <= granted index + 1 (mod NUM_WARPS) on grant; unchanged otherwise.
  - issue_stall=1 forces grant=0, and p and scoreboard are unchanged by issue. The ring still shifts and writebacks still clear.
- Issue effects at the edge ending grant cycle t:
  - ALU: slot[0] <= {1,w,rd,0}, so wb in cycle t+1.
  - FP: slot[FP_LATENCY-1] <= {1,w,rd,1}, so wb in cycle t+FP_LATENCY. Also pending[w][rd] <= 1 and fp_inflight+1.
- Writeback: when slot[0].valid and is_fp, pending[wb_warp][wb_rd] <= 0 at that edge and fp_inflight-1.
  - Simultaneous FP issue and FP writeback leave fp_inflight unchanged.
  - A clear is not visible to eligibility until the next cycle; no same-cycle bypass.
  - A set and a clear on the same {warp,rd} cannot coincide because pending blocks issue.
- ALU ops do not set the scoreboard; the datapath forwards their results.
- fp_inflight never exceeds FP_LATENCY.

Test Plan:
- Reset then req=0 -> grant=0, wb_valid=0, fp_inflight=0. Assert rst_n=0 while 3 FP in flight -> no wb ever appears and fp_inflight=0 immediately.
- FP_LATENCY=4. Warp 2 FP rd=5 granted in cycle 10 -> wb_valid=1 with wb_warp=2, wb_rd=5, wb_is_fp=1 in cycle 14. fp_inflight is 1 during cycles 11-14 and 0 at 15.
- Warp 2 FP rd=5 at cycle 10, then warp 2 requests ALU with rs1=5 -> no grant cycles 11-14. Grant in cycle 15, wb in 16.
- Warps 0,1,3 requesting ALU continuously with no hazards -> grants rotate 0,1,3,0,1,3 with one wb per cycle, one cycle after each grant.
- FP granted cycle 10 (wb cycle 14); ALU-only warp requesting in cycle 13 -> not granted in 13 (slot[1] busy), granted in 14, wb in 15. No cycle has two writebacks.
- issue_stall=1 in cycles 20-22 with req=all ones -> grant=0 and pointer frozen. In-flight FP wb still occurs on schedule. Grant resumes at stored pointer in cycle 23.

Source files
------------

// File: rtl/fpu_issue_scheduler_if.sv
// fpu_issue_scheduler_if: issue/writeback bus between warp requesters and the FPU issue scheduler.
//   master: drives req*, issue_stall; observes grant*, wb*, fp_inflight (warp scheduler / datapath side)
//   slave : the scheduler itself
interface fpu_issue_scheduler_if #(
    parameter int NUM_WARPS  = 8,
    parameter int FP_LATENCY = 4,
    parameter int REG_BITS   = 5
);
    localparam int WW = $clog2(NUM_WARPS);
    localparam int CW = $clog2(FP_LATENCY) + 1;
    logic [NUM_WARPS-1:0]          req;
    logic [NUM_WARPS-1:0]          req_is_fp;
    logic [NUM_WARPS*REG_BITS-1:0] req_rd;
    logic [NUM_WARPS*REG_BITS-1:0] req_rs1;
    logic [NUM_WARPS*REG_BITS-1:0] req_rs2;
    logic                          issue_stall;
    logic [NUM_WARPS-1:0]          grant;
    logic                          grant_valid;
    logic [WW-1:0]                 grant_warp;
    logic                          grant_is_fp;
    logic                          wb_valid;
    logic [WW-1:0]                 wb_warp;
    logic [REG_BITS-1:0]           wb_rd;
    logic                          wb_is_fp;
    logic [CW-1:0]                 fp_inflight;
    modport master (
        output req, req_is_fp, req_rd, req_rs1, req_rs2, issue_stall,
        input  grant, grant_valid, grant_warp, grant_is_fp,
        input  wb_valid, wb_warp, wb_rd, wb_is_fp, fp_inflight
    );
    modport slave (
        input  req, req_is_fp, req_rd, req_rs1, req_rs2, issue_stall,
        output grant, grant_valid, grant_warp, grant_is_fp,
        output wb_valid, wb_warp, wb_rd, wb_is_fp, fp_inflight
    );
endinterface

// File: rtl/fpu_issue_scheduler.sv
// fpu_issue_scheduler: round-robin single-issue arbiter for a shared ALU+FPU datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fpu_issue_scheduler_if (requests in, grant/writeback/fp_inflight out)
// A per-warp scoreboard blocks RAW/WAW against in-flight FP results, and a writeback
// slot ring keeps single-cycle ALU results from landing on the RF port with an FP result.
module fpu_issue_scheduler #(
    parameter int NUM_WARPS  = 8,
    parameter int FP_LATENCY = 4,
    parameter int REG_BITS   = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    fpu_issue_scheduler_if.slave bus
);
    localparam int WW = $clog2(NUM_WARPS);
    localparam int CW = $clog2(FP_LATENCY) + 1;
    localparam int NR = 2 ** REG_BITS;
    logic [FP_LATENCY-1:0]               slot_v_q, slot_v_d, slot_fp_q, slot_fp_d;
    logic [WW-1:0]                       slot_w_q [FP_LATENCY];
    logic [WW-1:0]                       slot_w_d [FP_LATENCY];
    logic [REG_BITS-1:0]                 slot_rd_q [FP_LATENCY];
    logic [REG_BITS-1:0]                 slot_rd_d [FP_LATENCY];
    logic [NUM_WARPS-1:0][NR-1:0]        pend_q, pend_d;
    logic [WW-1:0]                       ptr_q, ptr_d;
    logic [CW-1:0]                       fp_inflight_q, fp_inflight_d;
    logic [REG_BITS-1:0]                 rd_a [NUM_WARPS];
    logic [REG_BITS-1:0]                 rs1_a [NUM_WARPS];
    logic [REG_BITS-1:0]                 rs2_a [NUM_WARPS];
    logic [NUM_WARPS-1:0]                elig;
    logic [WW-1:0]                       gw, idx;
    logic                                found, gv, gfp, wb_fp;
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_elig
        assign rd_a[w]  = bus.req_rd[w*REG_BITS +: REG_BITS];
        assign rs1_a[w] = bus.req_rs1[w*REG_BITS +: REG_BITS];
        assign rs2_a[w] = bus.req_rs2[w*REG_BITS +: REG_BITS];
        // an ALU op would write back next cycle, exactly when slot[1] reaches the port
        assign elig[w] = bus.req[w] & ~pend_q[w][rd_a[w]] & ~pend_q[w][rs1_a[w]] &
                         ~pend_q[w][rs2_a[w]] & (bus.req_is_fp[w] | ~slot_v_q[1]);
    end
    always_comb begin
        found = 1'b0;
        gw    = '0;
        idx   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = ptr_q + WW'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gw    = idx;
            end
        end
    end
    assign gv    = found & ~bus.issue_stall;
    assign gfp   = gv & bus.req_is_fp[gw];
    assign wb_fp = slot_v_q[0] & slot_fp_q[0];
    assign bus.grant       = NUM_WARPS'(gv) << gw;
    assign bus.grant_valid = gv;
    assign bus.grant_warp  = gv ? gw : '0;
    assign bus.grant_is_fp = gfp;
    assign bus.wb_valid    = slot_v_q[0];
    assign bus.wb_warp     = slot_v_q[0] ? slot_w_q[0] : '0;
    assign bus.wb_rd       = slot_v_q[0] ? slot_rd_q[0] : '0;
    assign bus.wb_is_fp    = wb_fp;
    assign bus.fp_inflight = fp_inflight_q;
    always_comb begin
        slot_v_d  = {1'b0, slot_v_q[FP_LATENCY-1:1]};
        slot_fp_d = {1'b0, slot_fp_q[FP_LATENCY-1:1]};
        for (int k = 0; k < FP_LATENCY - 1; k++) begin
            slot_w_d[k]  = slot_w_q[k+1];
            slot_rd_d[k] = slot_rd_q[k+1];
        end
        slot_w_d[FP_LATENCY-1]  = '0;
        slot_rd_d[FP_LATENCY-1] = '0;
        pend_d = pend_q;
        // clear before set: the same {warp,rd} can never be both, since pending blocks issue
        if (wb_fp) pend_d[slot_w_q[0]][slot_rd_q[0]] = 1'b0;
        if (gfp) begin
            slot_v_d[FP_LATENCY-1]  = 1'b1;
            slot_fp_d[FP_LATENCY-1] = 1'b1;
            slot_w_d[FP_LATENCY-1]  = gw;
            slot_rd_d[FP_LATENCY-1] = rd_a[gw];
            pend_d[gw][rd_a[gw]]    = 1'b1;
        end else if (gv) begin
            slot_v_d[0]  = 1'b1;
            slot_fp_d[0] = 1'b0;
            slot_w_d[0]  = gw;
            slot_rd_d[0] = rd_a[gw];
        end
        ptr_d         = gv ? gw + WW'(1) : ptr_q;
        fp_inflight_d = fp_inflight_q + CW'(gfp) - CW'(wb_fp);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q      <= '0;
            slot_fp_q     <= '0;
            slot_w_q      <= '{default: '0};
            slot_rd_q     <= '{default: '0};
            pend_q        <= '0;
            ptr_q         <= '0;
            fp_inflight_q <= '0;
        end else begin
            slot_v_q      <= slot_v_d;
            slot_fp_q     <= slot_fp_d;
            slot_w_q      <= slot_w_d;
            slot_rd_q     <= slot_rd_d;
            pend_q        <= pend_d;
            ptr_q         <= ptr_d;
            fp_inflight_q <= fp_inflight_d;
        end
    end
endmodule
